// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter:
// operation codes and the control bundle carried through each stage.
package pipelined_barrel_shifter_pkg;

  typedef enum logic [2:0] {
    OPR_LSR  = 3'b000,
    OPR_ASR  = 3'b001,
    OPR_ROR  = 3'b010,
    OPR_RSV0 = 3'b011,
    OPR_LSL  = 3'b100,
    OPR_ASL  = 3'b101,
    OPR_ROL  = 3'b110,
    OPR_RSV1 = 3'b111
  } opr_e;

  typedef struct packed {
    opr_e opr;
    logic cout;
    logic ovf;
  } ctrl_t;

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready streaming bus of the pipelined barrel shifter.
// master drives operations and OREADY; slave is the shifter.
interface pipelined_barrel_shifter_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
);
  logic                   IVALID;
  logic                   IREADY;
  logic [DATA_WIDTH-1:0]  IDATA;
  logic [SHIFT_WIDTH-1:0] N_SHIFT;
  logic [2:0]             OPR;
  logic                   OVALID;
  logic                   OREADY;
  logic [DATA_WIDTH-1:0]  ODATA;
  logic                   COUT;
  logic                   OVF;

  modport master (
    output IVALID, IDATA, N_SHIFT, OPR, OREADY,
    input  IREADY, OVALID, ODATA, COUT, OVF
  );

  modport slave (
    input  IVALID, IDATA, N_SHIFT, OPR, OREADY,
    output IREADY, OVALID, ODATA, COUT, OVF
  );
endinterface

// File: rtl/bs_pipe_stage.sv
// One log-shift stage: conditional 2^STAGE shift/rotate and its
// valid/data/ctrl register with stall-aware load logic.
module bs_pipe_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int STAGE       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SHIFT_WIDTH-1:0] in_n,
  input  ctrl_t                  in_ctrl,
  input  logic                   next_load,
  output logic                   load,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [SHIFT_WIDTH-1:0] out_n,
  output ctrl_t                  out_ctrl
);

  localparam int S = 1 << STAGE;

  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [SHIFT_WIDTH-1:0] n_q, n_d;
  ctrl_t                  ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0]  sh;

  assign load = ~valid_q | next_load;

  always_comb begin
    sh = in_data;
    if (in_n[STAGE]) begin
      unique case (in_ctrl.opr)
        OPR_LSR:          sh = in_data >> S;
        OPR_ASR:          sh = $signed(in_data) >>> S;
        OPR_ROR:          sh = (in_data >> S) | (in_data << (DATA_WIDTH - S));
        OPR_LSL, OPR_ASL: sh = in_data << S;
        OPR_ROL:          sh = (in_data << S) | (in_data >> (DATA_WIDTH - S));
        default:          sh = in_data;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    n_d     = n_q;
    ctrl_d  = ctrl_q;
    if (load) begin
      valid_d = in_valid;
      data_d  = sh;
      n_d     = in_n;
      ctrl_d  = in_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      n_q     <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      n_q     <= n_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_n     = n_q;
  assign out_ctrl  = ctrl_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: flags resolved up front, then one
// registered log-shift stage per shift-amount bit.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input logic                  CLK,
  input logic                  RST,
  pipelined_barrel_shifter_if.slave bus
);

  logic                   v_c  [SHIFT_WIDTH+1];
  logic [DATA_WIDTH-1:0]  d_c  [SHIFT_WIDTH+1];
  logic [SHIFT_WIDTH-1:0] n_c  [SHIFT_WIDTH+1];
  ctrl_t                  c_c  [SHIFT_WIDTH+1];
  logic                   ld_c [SHIFT_WIDTH];

  opr_e                   opr;
  ctrl_t                  ctrl0;
  logic [SHIFT_WIDTH-1:0] idx_lo, idx_hi;
  logic [DATA_WIDTH-1:0]  mask, top;
  logic                   unused_n;

  // Flags depend only on the original operand, so resolve them here.
  always_comb begin
    opr    = opr_e'(bus.OPR);
    idx_lo = bus.N_SHIFT - SHIFT_WIDTH'(1);
    idx_hi = '0 - bus.N_SHIFT;
    mask   = ~(({DATA_WIDTH{1'b1}} >> bus.N_SHIFT) >> 1);
    top    = bus.IDATA & mask;
    ctrl0  = '0;
    ctrl0.opr = opr;
    if (bus.N_SHIFT != '0) begin
      unique case (opr)
        OPR_LSR, OPR_ASR, OPR_ROR:
          ctrl0.cout = bus.IDATA[idx_lo];
        OPR_LSL, OPR_ROL:
          ctrl0.cout = bus.IDATA[idx_hi];
        OPR_ASL: begin
          ctrl0.cout = bus.IDATA[idx_hi];
          ctrl0.ovf  = (top != '0) && (top != mask);
        end
        default: ctrl0 = ctrl0;
      endcase
    end
  end

  assign v_c[0] = bus.IVALID;
  assign d_c[0] = bus.IDATA;
  assign n_c[0] = bus.N_SHIFT;
  assign c_c[0] = ctrl0;

  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    logic nxt;
    if (k == SHIFT_WIDTH - 1) begin : g_last
      assign nxt = bus.OREADY;
    end else begin : g_mid
      assign nxt = ld_c[k+1];
    end

    bs_pipe_stage #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH),
      .STAGE       (k)
    ) u_stage (
      .clk       (CLK),
      .rst       (RST),
      .in_valid  (v_c[k]),
      .in_data   (d_c[k]),
      .in_n      (n_c[k]),
      .in_ctrl   (c_c[k]),
      .next_load (nxt),
      .load      (ld_c[k]),
      .out_valid (v_c[k+1]),
      .out_data  (d_c[k+1]),
      .out_n     (n_c[k+1]),
      .out_ctrl  (c_c[k+1])
    );
  end

  assign unused_n   = ^n_c[SHIFT_WIDTH];
  assign bus.IREADY = ld_c[0];
  assign bus.OVALID = v_c[SHIFT_WIDTH];
  assign bus.ODATA  = d_c[SHIFT_WIDTH];
  assign bus.COUT   = c_c[SHIFT_WIDTH].cout;
  assign bus.OVF    = c_c[SHIFT_WIDTH].ovf;

endmodule
